freq_gate_counter: RTL and testbench
====================================

# freq_gate_counter

Gated frequency meter sitting directly downstream of the clock divider. It takes the 0.5 Hz gate (1 s high, 1 s low) and an external measured signal, and counts rising edges of the signal while the gate is high. On gate fall it latches the count and converts it to packed BCD for the display stage. Everything runs on the 50 MHz system clock; gate and signal are treated as asynchronous inputs.

## Interface
- CNT_W, 27, edge counter / binary result width (covers 99,999,999)
- DIGITS, 8, BCD digits in result
- SYNC_STAGES, 2, synchronizer depth for gate_in and sig_in (≥2)

Clock and reset: one clock; reset is asynchronous and active-low.
- sysclk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- gate_in  in  1  measurement gate from divider, async
- sig_in  in  1  signal under measurement, async, ≤ 25 MHz
- freq_bin  out  CNT_W  last latched edge count
- freq_bcd  out  4*DIGITS  packed BCD of freq_bin, digit 0 in [3:0]
- overflow  out  1  last window saturated counter or exceeded 10^DIGITS−1
- valid  out  1  one-cycle pulse when freq_bcd/overflow update
- busy  out  1  BCD conversion in progress

## Operation
- gate_in and sig_in each pass through SYNC_STAGES flops, then one edge-detect flop. Sync/edge flops reset to 0.
- Control FSM, reset state ARM:
  - ARM: wait for synced gate = 0 → READY. A window already open when reset is released is discarded.
  - READY: on gate rise → COUNT; counter loads 1 if a sig rise occurs that same cycle, else 0.
  - COUNT: +1 per synced sig rise; saturates at 2^CNT_W−1 and sets a sticky sat flag. On gate fall → snapshot: freq_bin ← counter, start conversion, → READY. A sig rise on the fall cycle is not counted.
- Converter: sequential shift-add-3 (double dabble), one bit per cycle, CNT_W cycles. Result is clamped when snapshot > 10^DIGITS−1 or sat is set: freq_bcd ← all 9s, overflow ← 1; otherwise overflow ← 0.
- A new snapshot while busy aborts the current conversion and restarts with the new value. No valid is issued for the aborted one.
- All outputs reset to 0. ARM applies after any reset, including mid-count or mid-conversion.

## Timing
- Input-to-edge latency: SYNC_STAGES+1 cycles for both inputs, so relative alignment is preserved.
- freq_bin updates the cycle after gate-fall detection. busy rises the same cycle.
- busy stays high for CNT_W cycles. freq_bcd, overflow and valid are registered at the end; valid is high for exactly one cycle as busy falls.
- Total latency from the synced gate fall to valid: CNT_W+1 cycles (28 at default).
- freq_bcd holds its value between valid pulses.
- Sig pulses narrower than one sysclk period may be missed; this is not an error condition.

## Structure
- Shared package holds the CNT_W/DIGITS defaults, the FSM state encoding (ARM, READY, COUNT) and the BCD max constant 10^DIGITS−1.
- Sub-module bin2bcd_seq: start, bin in, bcd out, done. It owns the shift/add-3 iteration and counter.
- The top holds the synchronizers, edge detect, FSM, edge counter, saturation logic and clamp.

## Test plan
- Gate high 10,000 cycles, sig period 50 cycles, first rise 10 cycles after the gate rise → freq_bin = 200, freq_bcd = 0x00000200, overflow = 0, valid 28 cycles after the synced fall.
- sig_in held at 0 through a full window → freq_bin = 0, freq_bcd = 0, valid pulses once.
- CNT_W = 8, DIGITS = 2, 300 sig edges in window → freq_bin = 255, overflow = 1, freq_bcd = 0x99. Then 99 edges → 0x99 with overflow = 0.
- Reset released with gate_in already high, 50 edges → no valid; the next full window of 40 edges → freq_bin = 40, 0x40.
- Two 20-cycle windows separated by 5 low cycles (CNT_W = 27) → first conversion aborted, one valid only, carrying the second window's count.
- reset asserted mid-COUNT and mid-conversion → all outputs 0 immediately, busy = 0, no valid until the next complete window.

Source files
------------

// File: rtl/freq_gate_counter_pkg.sv
// Shared definitions for the gated frequency meter: default widths,
// control FSM encoding and the largest value representable in BCD.
package freq_gate_counter_pkg;

  localparam int CNT_W_DEF       = 27;
  localparam int DIGITS_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,  // waiting for the gate to be seen low after reset
    ST_READY = 2'd1,  // gate low, waiting for the next window to open
    ST_COUNT = 2'd2   // window open, counting signal rising edges
  } state_e;

  // Largest value that fits in the given number of BCD digits (10^digits - 1).
  function automatic longint unsigned bcd_max(input int digits);
    longint unsigned v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  localparam longint unsigned BCD_MAX_DEF = bcd_max(DIGITS_DEF);

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3), one input bit
// per clock. A start while busy aborts the running conversion and reloads.
module bin2bcd_seq
  import freq_gate_counter_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic                  busy
);

  localparam int STEP_W = $clog2(CNT_W + 1);
  localparam int WORK_W = 4 * DIGITS + CNT_W;

  logic [CNT_W-1:0]    bin_sh;
  logic [4*DIGITS-1:0] bcd_work;
  logic [STEP_W-1:0]   step_q;
  logic                busy_q;

  logic [4*DIGITS-1:0] bcd_adj;
  logic [WORK_W-1:0]   shifted;
  logic [4*DIGITS-1:0] bcd_next;
  logic [CNT_W-1:0]    bin_next;
  logic                last_step;

  // One double-dabble iteration: correct each digit >= 5, then shift the
  // combined {bcd, bin} register left by one.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    bcd_adj = bcd_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_adj[4*d +: 4] > 4'd4) begin
        bcd_adj[4*d +: 4] = bcd_adj[4*d +: 4] + 4'd3;
      end
    end
    shifted  = {bcd_adj, bin_sh} << 1;
    bcd_next = shifted[WORK_W-1:CNT_W];
    bin_next = shifted[CNT_W-1:0];
  end

  assign last_step = (step_q == STEP_W'(CNT_W - 1));

  // bcd carries the finished result only in the cycle done is high; a
  // simultaneous restart suppresses done so an aborted run never reports.
  assign bcd  = bcd_next;
  assign done = busy_q && last_step && !start;
  assign busy = busy_q;

  // Iteration state: load on start, step while busy, drop busy after the last bit.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      bin_sh   <= '0;
      bcd_work <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      bin_sh   <= bin;
      bcd_work <= '0;
      step_q   <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      bin_sh   <= bin_next;
      bcd_work <= bcd_next;
      step_q   <= step_q + 1'b1;
      if (last_step) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/freq_gate_counter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in while
// gate_in is high, snapshots the count on gate fall and hands it to the
// BCD converter, clamping to all 9s when the count cannot be shown.
module freq_gate_counter
  import freq_gate_counter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIGITS      = DIGITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                gate_in,
  input  logic                sig_in,
  output logic [CNT_W-1:0]    freq_bin,
  output logic [4*DIGITS-1:0] freq_bcd,
  output logic                overflow,
  output logic                valid,
  output logic                busy
);

  localparam longint unsigned BCD_MAX = bcd_max(DIGITS);

  logic [SYNC_STAGES-1:0] gate_sync, sig_sync, primed_sr;
  logic                   gate_d, sig_d;
  logic                   gate_s, sig_s, primed;
  logic                   gate_rise, gate_fall, sig_rise;

  state_e                 state_q, state_d;
  logic                   load, snap;

  logic [CNT_W-1:0]       cnt_q;
  logic                   sat_q;
  logic                   clamp_q;

  logic [4*DIGITS-1:0]    conv_bcd;
  logic                   conv_done;

  // Synchronizers and edge-detect flops; primed_sr marks when the sync chain
  // holds real post-reset samples so ARM cannot mistake reset zeros for a closed gate.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      gate_sync <= '0;
      sig_sync  <= '0;
      primed_sr <= '0;
      gate_d    <= 1'b0;
      sig_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value of the previous one.
      gate_sync <= {gate_sync[SYNC_STAGES-2:0], gate_in};
      sig_sync  <= {sig_sync[SYNC_STAGES-2:0], sig_in};
      primed_sr <= {primed_sr[SYNC_STAGES-2:0], 1'b1};
      gate_d    <= gate_s;
      sig_d     <= sig_s;
    end
  end

  assign gate_s    = gate_sync[SYNC_STAGES-1];
  assign sig_s     = sig_sync[SYNC_STAGES-1];
  assign primed    = primed_sr[SYNC_STAGES-1];
  assign gate_rise = gate_s & ~gate_d;
  assign gate_fall = ~gate_s & gate_d;
  assign sig_rise  = sig_s & ~sig_d;

  // Control FSM state register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ARM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and window control: open on gate rise, snapshot on gate fall.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    snap    = 1'b0;
    case (state_q)
      ST_ARM: begin
        if (primed && !gate_s) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (gate_rise) begin
          state_d = ST_COUNT;
          load    = 1'b1;
        end
      end
      ST_COUNT: begin
        if (gate_fall) begin
          state_d = ST_READY;
          snap    = 1'b1;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  // Edge counter with sticky saturation; an edge on the fall cycle is ignored.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (load) begin
      cnt_q <= sig_rise ? CNT_W'(1) : '0;
      sat_q <= 1'b0;
    end else if (state_q == ST_COUNT && !gate_fall && sig_rise) begin
      if (&cnt_q) begin
        sat_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Snapshot of the finished window and whether its BCD form must be clamped.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      freq_bin <= '0;
      clamp_q  <= 1'b0;
    end else if (snap) begin
      freq_bin <= cnt_q;
      clamp_q  <= sat_q || (64'(cnt_q) > BCD_MAX);
    end
  end

  bin2bcd_seq #(
    .CNT_W  (CNT_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .sysclk (sysclk),
    .reset  (reset),
    .start  (snap),
    .bin    (cnt_q),
    .bcd    (conv_bcd),
    .done   (conv_done),
    .busy   (busy)
  );

  // Result register: updated and flagged valid only when a conversion completes.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      freq_bcd <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= conv_done;
      if (conv_done) begin
        freq_bcd <= clamp_q ? {DIGITS{4'h9}} : conv_bcd;
        overflow <= clamp_q;
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter: a default-size instance (27-bit,
// 8 digits) and a small instance (8-bit, 2 digits) share clock and reset.
module tb_freq_gate_counter;

  localparam int SYNC  = 2;
  localparam int W_A   = 27;
  localparam int W_B   = 8;
  localparam int TAIL  = 5;
  localparam int N_VEC = 12;

  typedef struct {
    bit          sel;      // 0: default instance, 1: small instance
    int          high;     // gate high cycles
    int          period;   // sig period in cycles, 0 = sig held low
    int          first;    // offset of first sig rise from gate rise
    int          exp_bin;
    logic [31:0] exp_bcd;
    bit          exp_ovf;
  } vec_t;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  logic gate_a = 1'b0, sig_a = 1'b0;
  logic gate_b = 1'b0, sig_b = 1'b0;

  logic [W_A-1:0] bin_a;
  logic [31:0]    bcd_a;
  logic           ovf_a, valid_a, busy_a;
  logic [W_B-1:0] bin_b;
  logic [7:0]     bcd_b;
  logic           ovf_b, valid_b, busy_b;

  int n_vec = 0;
  int n_bad = 0;

  int cyc = 0;
  int vcnt_a = 0, vcnt_b = 0, vcyc_a = 0, vcyc_b = 0;
  int bcnt_a = 0, bcnt_b = 0;
  int fall_cyc = 0;

  vec_t vecs [N_VEC];

  always #10 sysclk = ~sysclk;

  freq_gate_counter dut_a (
    .sysclk   (sysclk),
    .reset    (reset),
    .gate_in  (gate_a),
    .sig_in   (sig_a),
    .freq_bin (bin_a),
    .freq_bcd (bcd_a),
    .overflow (ovf_a),
    .valid    (valid_a),
    .busy     (busy_a)
  );

  freq_gate_counter #(.CNT_W(W_B), .DIGITS(2)) dut_b (
    .sysclk   (sysclk),
    .reset    (reset),
    .gate_in  (gate_b),
    .sig_in   (sig_b),
    .freq_bin (bin_b),
    .freq_bcd (bcd_b),
    .overflow (ovf_b),
    .valid    (valid_b),
    .busy     (busy_b)
  );

  // Cycle counter plus running counts of valid pulses and busy cycles.
  always @(posedge sysclk) begin
    cyc++;
    #1;
    if (valid_a) begin vcnt_a++; vcyc_a = cyc; end
    if (valid_b) begin vcnt_b++; vcyc_b = cyc; end
    if (busy_a) bcnt_a++;
    if (busy_b) bcnt_b++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int vcnt_of(input bit sel);
    return sel ? vcnt_b : vcnt_a;
  endfunction

  function automatic int vcyc_of(input bit sel);
    return sel ? vcyc_b : vcyc_a;
  endfunction

  function automatic int bcnt_of(input bit sel);
    return sel ? bcnt_b : bcnt_a;
  endfunction

  // One gate window of `high` cycles followed by `tail` low cycles. The sig
  // pattern runs through offset `high` (the fall cycle) and is low after.
  task automatic run_window(input bit sel, input int high, input int period,
                            input int first, input int tail);
    int  width;
    bit  s;
    width = (period > 1) ? period / 2 : 1;
    for (int c = 0; c < high + tail; c++) begin
      s = (period > 0) && (c >= first) && (c <= high) && (((c - first) % period) < width);
      @(negedge sysclk);
      if (c == high) fall_cyc = cyc;
      if (sel) begin gate_b = (c < high); sig_b = s; end
      else     begin gate_a = (c < high); sig_a = s; end
    end
  endtask

  // Wait for the result of a window and compare everything it produced.
  task automatic check_window(input string tag, input bit sel, input int vbefore,
                              input int bbefore, input int exp_bin,
                              input logic [31:0] exp_bcd, input bit exp_ovf,
                              input bit chk_busy);
    int lat_exp;
    // input drop -> synced fall takes SYNC cycles, then CNT_W+1 to valid
    lat_exp = sel ? (SYNC + W_B + 1) : (SYNC + W_A + 1);
    for (int k = 0; k < 100; k++) begin
      if (vcnt_of(sel) > vbefore) break;
      @(posedge sysclk); #2;
    end
    repeat (40) @(posedge sysclk);
    #2;
    check({tag, " valid_pulses"}, 64'(vcnt_of(sel) - vbefore), 64'd1);
    check({tag, " latency"}, 64'(vcyc_of(sel) - fall_cyc), 64'(lat_exp));
    if (chk_busy)
      check({tag, " busy_cycles"}, 64'(bcnt_of(sel) - bbefore), sel ? 64'(W_B) : 64'(W_A));
    check({tag, " freq_bin"}, sel ? 64'(bin_b) : 64'(bin_a), 64'(exp_bin));
    check({tag, " freq_bcd"}, sel ? 64'(bcd_b) : 64'(bcd_a), 64'(exp_bcd));
    check({tag, " overflow"}, sel ? 64'(ovf_b) : 64'(ovf_a), 64'(exp_ovf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " freq_bin"}, 64'(bin_a), 64'd0);
    check({tag, " freq_bcd"}, 64'(bcd_a), 64'd0);
    check({tag, " overflow"}, 64'(ovf_a), 64'd0);
    check({tag, " valid"},    64'(valid_a), 64'd0);
    check({tag, " busy"},     64'(busy_a), 64'd0);
  endtask

  initial begin
    int vb, bb;

    vecs[0]  = '{0, 10000, 50, 10, 200,  32'h0000_0200, 0};
    vecs[1]  = '{0, 1000,  0,  0,  0,    32'h0000_0000, 0};
    vecs[2]  = '{0, 1000,  10, 0,  100,  32'h0000_0100, 0};
    vecs[3]  = '{0, 100,   4,  3,  25,   32'h0000_0025, 0};
    vecs[4]  = '{0, 100,   5,  0,  20,   32'h0000_0020, 0};
    vecs[5]  = '{0, 2000,  2,  0,  1000, 32'h0000_1000, 0};
    vecs[6]  = '{0, 297,   3,  0,  99,   32'h0000_0099, 0};
    vecs[7]  = '{1, 600,   2,  0,  255,  32'h0000_0099, 1};
    vecs[8]  = '{1, 198,   2,  0,  99,   32'h0000_0099, 0};
    vecs[9]  = '{1, 200,   2,  0,  100,  32'h0000_0099, 1};
    vecs[10] = '{1, 14,    2,  0,  7,    32'h0000_0007, 0};
    vecs[11] = '{1, 84,    2,  0,  42,   32'h0000_0042, 0};

    // Reset state of both instances.
    #5;
    check_all_zero("reset_a");
    check("reset_b freq_bin", 64'(bin_b), 64'd0);
    check("reset_b freq_bcd", 64'(bcd_b), 64'd0);
    check("reset_b overflow", 64'(ovf_b), 64'd0);
    check("reset_b valid",    64'(valid_b), 64'd0);
    check("reset_b busy",     64'(busy_b), 64'd0);
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    repeat (5) @(negedge sysclk);

    // Table of complete windows.
    for (int i = 0; i < N_VEC; i++) begin
      vb = vcnt_of(vecs[i].sel);
      bb = bcnt_of(vecs[i].sel);
      run_window(vecs[i].sel, vecs[i].high, vecs[i].period, vecs[i].first, TAIL);
      check_window($sformatf("vec%0d", i), vecs[i].sel, vb, bb, vecs[i].exp_bin,
                   vecs[i].exp_bcd, vecs[i].exp_ovf, 1'b1);
    end

    // Two 20-cycle windows 5 cycles apart: first conversion is aborted.
    vb = vcnt_a;
    bb = bcnt_a;
    run_window(0, 20, 4, 0, 5);
    run_window(0, 20, 2, 0, TAIL);
    check_window("abort", 0, vb, bb, 10, 32'h10, 0, 1'b0);

    // Reset released with the gate already open: that window is discarded.
    @(negedge sysclk);
    reset  = 1'b0;
    gate_a = 1'b1;
    sig_a  = 1'b0;
    @(negedge sysclk);
    reset = 1'b1;
    vb = vcnt_a;
    for (int c = 0; c < 200; c++) begin
      @(negedge sysclk);
      gate_a = 1'b1;
      sig_a  = ((c % 4) < 2);
    end
    @(negedge sysclk);
    gate_a = 1'b0;
    sig_a  = 1'b0;
    repeat (60) @(posedge sysclk);
    #2;
    check("open_at_reset no_valid", 64'(vcnt_a - vb), 64'd0);
    check("open_at_reset freq_bin", 64'(bin_a), 64'd0);
    vb = vcnt_a;
    bb = bcnt_a;
    run_window(0, 400, 10, 5, TAIL);
    check_window("after_open", 0, vb, bb, 40, 32'h40, 0, 1'b1);

    // Reset asserted in the middle of a counting window.
    for (int c = 0; c < 30; c++) begin
      @(negedge sysclk);
      gate_a = 1'b1;
      sig_a  = ((c % 2) == 0);
    end
    @(negedge sysclk);
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid_count");
    @(negedge sysclk);
    reset = 1'b1;
    vb = vcnt_a;
    for (int c = 0; c < 20; c++) begin
      @(negedge sysclk);
      gate_a = 1'b1;
      sig_a  = ((c % 2) == 0);
    end
    @(negedge sysclk);
    gate_a = 1'b0;
    sig_a  = 1'b0;
    repeat (60) @(posedge sysclk);
    #2;
    check("rst_mid_count no_valid", 64'(vcnt_a - vb), 64'd0);

    // Reset asserted while a conversion is running.
    run_window(0, 50, 5, 0, TAIL);
    #1;
    check("mid_conv busy", 64'(busy_a), 64'd1);
    check("mid_conv freq_bin", 64'(bin_a), 64'd10);
    @(negedge sysclk);
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid_conv");
    @(negedge sysclk);
    reset = 1'b1;
    vb = vcnt_a;
    repeat (60) @(posedge sysclk);
    #2;
    check("rst_mid_conv no_valid", 64'(vcnt_a - vb), 64'd0);
    vb = vcnt_a;
    bb = bcnt_a;
    run_window(0, 120, 10, 0, TAIL);
    check_window("after_rst", 0, vb, bb, 12, 32'h12, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
